// File: rtl/branch_predictor_bimodal.sv
// Branch predictor: tagged BTB with 2-bit bimodal counters and a return-address stack.
// Lookup of the fetch PC is combinational; EX resolution flushes and trains at the clock edge.
module branch_predictor_bimodal #(
  parameter int ADDR_W      = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int RAS_DEPTH   = 4,
  parameter int PRED_MODE   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              if_pred_branch,
  output logic              if_pred_taken,
  output logic [ADDR_W-1:0] if_pred_npc,
  output logic              flush,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_pred_npc,
  input  logic              ex_pred_branch,
  input  logic              ex_is_branch,
  input  logic              ex_is_cond,
  input  logic              ex_is_call,
  input  logic              ex_is_ret,
  input  logic              ex_is_taken,
  input  logic [ADDR_W-1:0] ex_target,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispred
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int RAS_W = $clog2(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);
  localparam logic [RAS_W:0]    RAS_FULL  = (RAS_W + 1)'(RAS_DEPTH);

  logic [BTB_ENTRIES-1:0] valid_r;
  logic [BTB_ENTRIES-1:0] cond_r;
  logic [BTB_ENTRIES-1:0] ret_r;
  logic [TAG_W-1:0]       tag_r    [BTB_ENTRIES];
  logic [ADDR_W-1:0]      target_r [BTB_ENTRIES];
  logic [1:0]             ctr_r    [BTB_ENTRIES];
  logic [ADDR_W-1:0]      ras_r    [RAS_DEPTH];
  logic [RAS_W-1:0]       ras_ptr_r;
  logic [RAS_W:0]         ras_count_r;
  logic [31:0]            perf_branches_r;
  logic [31:0]            perf_mispred_r;

  logic [IDX_W-1:0]  if_idx_s;
  logic [TAG_W-1:0]  if_tag_s;
  logic [IDX_W-1:0]  ex_idx_s;
  logic [TAG_W-1:0]  ex_tag_s;
  logic              if_hit_s;
  logic              if_taken_s;
  logic [ADDR_W-1:0] if_target_s;
  logic [ADDR_W-1:0] ex_actual_s;
  logic              flush_s;
  logic              ex_hit_s;
  logic [1:0]        ctr_next_s;
  logic              train_en_s;
  logic              unused_s;

  assign if_idx_s   = if_pc[IDX_W+1:2];
  assign if_tag_s   = if_pc[ADDR_W-1:IDX_W+2];
  assign ex_idx_s   = ex_pc[IDX_W+1:2];
  assign ex_tag_s   = ex_pc[ADDR_W-1:IDX_W+2];
  assign train_en_s = (PRED_MODE != 0) && ex_valid;
  assign unused_s   = ^{if_pc[1:0], ex_pc[1:0]};

  // Fetch-side lookup, resolution check and next-PC select.
  always_comb begin
    if_hit_s    = 1'b0;
    if_target_s = target_r[if_idx_s];
    if (PRED_MODE != 0) begin
      if_hit_s = valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s);
    end else begin
      if_hit_s = 1'b0;
    end
    if_taken_s = if_hit_s && (!cond_r[if_idx_s] || ctr_r[if_idx_s][1]);
    // A return only trusts the stack while it holds something.
    if (ret_r[if_idx_s] && (ras_count_r != '0)) begin
      if_target_s = ras_r[ras_ptr_r - RAS_W'(1)];
    end else begin
      if_target_s = target_r[if_idx_s];
    end
    ex_actual_s = ex_is_taken ? ex_target : (ex_pc + PC_STEP);
    flush_s     = ex_valid && (ex_actual_s != ex_pred_npc);
    if (flush_s) begin
      if_pred_npc = ex_actual_s;
    end else if (if_taken_s) begin
      if_pred_npc = if_target_s;
    end else begin
      if_pred_npc = if_pc + PC_STEP;
    end
  end

  // Next counter value for the entry addressed by the EX instruction.
  always_comb begin
    ex_hit_s   = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);
    ctr_next_s = ctr_r[ex_idx_s];
    if (!ex_is_cond) begin
      ctr_next_s = 2'b11;
    end else if (!ex_hit_s) begin
      ctr_next_s = ex_is_taken ? 2'b10 : 2'b01;
    end else if (ex_is_taken) begin
      ctr_next_s = (ctr_r[ex_idx_s] == 2'b11) ? 2'b11 : (ctr_r[ex_idx_s] + 2'b01);
    end else begin
      ctr_next_s = (ctr_r[ex_idx_s] == 2'b00) ? 2'b00 : (ctr_r[ex_idx_s] - 2'b01);
    end
  end

  assign if_pred_branch = if_hit_s;
  assign if_pred_taken  = if_taken_s;
  assign flush          = flush_s;
  assign perf_branches  = perf_branches_r;
  assign perf_mispred   = perf_mispred_r;

  // Table training, return stack and performance counters; reset wins over any update.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r         <= '0;
      ras_ptr_r       <= '0;
      ras_count_r     <= '0;
      perf_branches_r <= 32'd0;
      perf_mispred_r  <= 32'd0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        ctr_r[i] <= 2'b01;
      end
    end else begin
      if (train_en_s && ex_is_branch) begin
        ctr_r[ex_idx_s] <= ctr_next_s;
        if (!ex_hit_s) begin
          valid_r[ex_idx_s]  <= 1'b1;
          tag_r[ex_idx_s]    <= ex_tag_s;
          target_r[ex_idx_s] <= ex_target;
          cond_r[ex_idx_s]   <= ex_is_cond;
          ret_r[ex_idx_s]    <= ex_is_ret;
        end else if (ex_is_taken) begin
          target_r[ex_idx_s] <= ex_target;
        end
      end else if (train_en_s && ex_pred_branch) begin
        // A non-branch that hit in fetch means the entry aliases; drop it.
        valid_r[ex_idx_s] <= 1'b0;
      end
      if (train_en_s && ex_is_call) begin
        ras_r[ras_ptr_r] <= ex_pc + PC_STEP;
        ras_ptr_r        <= ras_ptr_r + RAS_W'(1);
        if (ras_count_r != RAS_FULL) begin
          ras_count_r <= ras_count_r + (RAS_W + 1)'(1);
        end
      end else if (train_en_s && ex_is_ret && (ras_count_r != '0)) begin
        ras_ptr_r   <= ras_ptr_r - RAS_W'(1);
        ras_count_r <= ras_count_r - (RAS_W + 1)'(1);
      end
      if (ex_valid && ex_is_branch) begin
        perf_branches_r <= perf_branches_r + 32'd1;
      end
      if (flush_s) begin
        perf_mispred_r <= perf_mispred_r + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_bimodal.sv
// Bench for branch_predictor_bimodal: a hand-written vector table driven into a bimodal
// instance and a static not-taken instance, with expected results queued and compared later.
module tb_branch_predictor_bimodal;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        ex_valid, ex_pred_branch, ex_is_branch, ex_is_cond, ex_is_call, ex_is_ret, ex_is_taken;
  logic [31:0] ex_pc, ex_pred_npc, ex_target;
  logic        br1, tk1, fl1, br0, tk0, fl0;
  logic [31:0] npc1, npc0, pb1, pm1, pb0, pm0;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    logic [31:0] if_pc;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_pred_npc;
    logic        pred_br, is_br, cond, call, ret, taken;
    logic [31:0] target;
    logic        e_br, e_tk;
    logic [31:0] e_npc;
    logic        e_fl;
  } vec_t;

  typedef struct {
    logic        br, tk, fl, fl0;
    logic [31:0] npc, npc0, pb, pm, pm0;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  branch_predictor_bimodal #(.ADDR_W(32), .BTB_ENTRIES(16), .RAS_DEPTH(4), .PRED_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .if_pred_branch(br1), .if_pred_taken(tk1), .if_pred_npc(npc1), .flush(fl1),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred_npc(ex_pred_npc), .ex_pred_branch(ex_pred_branch),
    .ex_is_branch(ex_is_branch), .ex_is_cond(ex_is_cond), .ex_is_call(ex_is_call),
    .ex_is_ret(ex_is_ret), .ex_is_taken(ex_is_taken), .ex_target(ex_target),
    .perf_branches(pb1), .perf_mispred(pm1)
  );

  branch_predictor_bimodal #(.ADDR_W(32), .BTB_ENTRIES(16), .RAS_DEPTH(4), .PRED_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .if_pred_branch(br0), .if_pred_taken(tk0), .if_pred_npc(npc0), .flush(fl0),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred_npc(ex_pred_npc), .ex_pred_branch(ex_pred_branch),
    .ex_is_branch(ex_is_branch), .ex_is_cond(ex_is_cond), .ex_is_call(ex_is_call),
    .ex_is_ret(ex_is_ret), .ex_is_taken(ex_is_taken), .ex_target(ex_target),
    .perf_branches(pb0), .perf_mispred(pm0)
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  function automatic vec_t lk(logic [31:0] pc, logic br, logic tk, logic [31:0] npc);
    vec_t v;
    v = '{default: '0};
    v.if_pc = pc; v.e_br = br; v.e_tk = tk; v.e_npc = npc; v.e_fl = 1'b0;
    return v;
  endfunction

  function automatic vec_t rs(logic [31:0] pc, logic [31:0] xpc, logic [31:0] pnpc, logic pbr,
                              logic isbr, logic cnd, logic cll, logic rt, logic tkn, logic [31:0] tgt,
                              logic br, logic tk, logic [31:0] npc, logic fl);
    vec_t v;
    v.if_pc = pc; v.ex_valid = 1'b1; v.ex_pc = xpc; v.ex_pred_npc = pnpc; v.pred_br = pbr;
    v.is_br = isbr; v.cond = cnd; v.call = cll; v.ret = rt; v.taken = tkn; v.target = tgt;
    v.e_br = br; v.e_tk = tk; v.e_npc = npc; v.e_fl = fl;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    if_pc = v.if_pc; ex_valid = v.ex_valid; ex_pc = v.ex_pc; ex_pred_npc = v.ex_pred_npc;
    ex_pred_branch = v.pred_br; ex_is_branch = v.is_br; ex_is_cond = v.cond; ex_is_call = v.call;
    ex_is_ret = v.ret; ex_is_taken = v.taken; ex_target = v.target;
  endtask

  initial begin
    logic [31:0] act0, tally_pb, tally_pm, tally_pm0;
    exp_t e;
    // Basic lookup, training up and down, saturation at 0.
    vecs.push_back(lk(32'h40, 1'b0, 1'b0, 32'h44));
    vecs.push_back(rs(32'h100, 32'h100, 32'h104, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h200, 1'b1));
    vecs.push_back(lk(32'h100, 1'b1, 1'b1, 32'h200));
    vecs.push_back(rs(32'h100, 32'h100, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 1'b0));
    vecs.push_back(rs(32'h40,  32'h100, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 1'b0, 1'b0, 32'h104, 1'b1));
    vecs.push_back(rs(32'h100, 32'h100, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 1'b1, 1'b1, 32'h104, 1'b1));
    vecs.push_back(lk(32'h100, 1'b1, 1'b0, 32'h104));
    vecs.push_back(rs(32'h100, 32'h100, 32'h104, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 1'b1, 1'b0, 32'h104, 1'b0));
    vecs.push_back(rs(32'h100, 32'h100, 32'h104, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 1'b1, 1'b0, 32'h104, 1'b0));
    vecs.push_back(lk(32'h100, 1'b1, 1'b0, 32'h104));
    // Alias replacement and alias invalidation.
    vecs.push_back(rs(32'h140, 32'h140, 32'h144, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h280, 1'b0, 1'b0, 32'h280, 1'b1));
    vecs.push_back(lk(32'h100, 1'b0, 1'b0, 32'h104));
    vecs.push_back(lk(32'h140, 1'b1, 1'b1, 32'h280));
    vecs.push_back(rs(32'h140, 32'h140, 32'h280, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h144, 1'b1));
    vecs.push_back(lk(32'h140, 1'b0, 1'b0, 32'h144));
    // Return stack: call, trained return, second call, predicted return.
    vecs.push_back(rs(32'h304, 32'h304, 32'h308, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 32'h400, 1'b1));
    vecs.push_back(rs(32'h508, 32'h508, 32'h50C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h308, 1'b0, 1'b0, 32'h308, 1'b1));
    vecs.push_back(rs(32'h508, 32'h70C, 32'h710, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 1'b1, 1'b1, 32'h400, 1'b1));
    vecs.push_back(lk(32'h508, 1'b1, 1'b1, 32'h710));
    vecs.push_back(rs(32'h508, 32'h508, 32'h710, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h710, 1'b1, 1'b1, 32'h710, 1'b0));
    vecs.push_back(lk(32'h508, 1'b1, 1'b1, 32'h710));
    // Five nested calls into a four-deep stack, then five returns.
    for (int k = 1; k <= 5; k++) begin
      vecs.push_back(rs(32'h0, 32'(k * 16), 32'(k * 16 + 4), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h400,
                        1'b0, 1'b0, 32'h400, 1'b1));
    end
    for (int k = 5; k >= 2; k--) begin
      vecs.push_back(rs(32'h508, 32'h508, 32'(k * 16 + 4), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'(k * 16 + 4),
                        1'b1, 1'b1, 32'(k * 16 + 4), 1'b0));
    end
    vecs.push_back(lk(32'h508, 1'b1, 1'b1, 32'h24));
    vecs.push_back(rs(32'h508, 32'h508, 32'h24, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 1'b1, 32'h14, 1'b1));
    vecs.push_back(lk(32'h508, 1'b1, 1'b1, 32'h14));
    vecs.push_back(lk(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0));

    rst = 1'b1;
    drive(lk(32'h0, 1'b0, 1'b0, 32'h0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tally_pb = 32'd0; tally_pm = 32'd0; tally_pm0 = 32'd0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      act0  = vecs[i].taken ? vecs[i].target : vecs[i].ex_pc + 32'd4;
      e.br  = vecs[i].e_br; e.tk = vecs[i].e_tk; e.npc = vecs[i].e_npc; e.fl = vecs[i].e_fl;
      e.fl0 = vecs[i].ex_valid && (act0 != vecs[i].ex_pred_npc);
      e.npc0 = e.fl0 ? act0 : vecs[i].if_pc + 32'd4;
      e.pb = tally_pb; e.pm = tally_pm; e.pm0 = tally_pm0;
      exp_q.push_back(e);
      tally_pb  = tally_pb + 32'(vecs[i].ex_valid && vecs[i].is_br);
      tally_pm  = tally_pm + 32'(vecs[i].e_fl);
      tally_pm0 = tally_pm0 + 32'(e.fl0);
      #3;
      e = exp_q.pop_front();
      chk("pred_branch", i, 32'(br1), 32'(e.br));
      chk("pred_taken", i, 32'(tk1), 32'(e.tk));
      chk("pred_npc", i, npc1, e.npc);
      chk("flush", i, 32'(fl1), 32'(e.fl));
      chk("perf_branches", i, pb1, e.pb);
      chk("perf_mispred", i, pm1, e.pm);
      chk("static_branch", i, 32'({br0, tk0}), 32'd0);
      chk("static_npc", i, npc0, e.npc0);
      chk("static_flush", i, 32'(fl0), 32'(e.fl0));
      chk("static_perf_br", i, pb0, e.pb);
      chk("static_perf_mp", i, pm0, e.pm0);
      @(negedge clk);
    end

    // Reset asserted while a taken branch resolves: nothing may be trained or counted.
    rst = 1'b1;
    drive(rs(32'h600, 32'h600, 32'h604, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h800, 1'b0, 1'b0, 32'h800, 1'b1));
    @(negedge clk);
    rst = 1'b0;
    drive(lk(32'h600, 1'b0, 1'b0, 32'h604));
    #3;
    chk("rst_pred_branch", 99, 32'(br1), 32'd0);
    chk("rst_pred_npc", 99, npc1, 32'h604);
    chk("rst_flush", 99, 32'(fl1), 32'd0);
    chk("rst_perf_branches", 99, pb1, 32'd0);
    chk("rst_perf_mispred", 99, pm1, 32'd0);
    drive(lk(32'h508, 1'b0, 1'b0, 32'h50C));
    #1;
    chk("rst_ret_miss", 100, 32'(br1), 32'd0);
    chk("rst_ret_npc", 100, npc1, 32'h50C);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
